ram_dp_clr: RTL and testbench

//  Parametrised single-clock memory: one write port, one registered read port.

---
 rtl/ram_dp_clr.sv | 158 +++++++++++++++
 tb/tb_ram_dp_clr.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_clr.sv
// Single-clock memory with one byte-enabled write port and one registered, write-first read port.
// A clear engine zeroes every word after reset and on request. Optional per-byte parity: `define PARITY_EN.
module ram_dp_clr #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 5,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [BE_W-1:0]   wr_be_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              clr_req_i,
    output logic              busy_o,
    output logic              parity_err_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                busy;
    logic                wr_fire;
    logic                rd_fire;
    logic                fwd;
    logic [DATA_W-1:0]   rd_word;

    assign busy    = (state_q == CLEAR);
    assign wr_fire = ena_i & wr_en_i & ~busy;
    assign rd_fire = ena_i & rd_en_i & ~busy;
    assign fwd     = wr_fire & (wr_addr_i == rd_addr_i);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clr_req_i) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Write-first: bytes being written this cycle at the read address bypass the array.
    always_comb begin
        rd_word = mem[rd_addr_i];
        for (int i = 0; i < BE_W; i++) begin
            if (fwd && wr_be_i[i]) begin
                rd_word[8*i +: 8] = wr_data_i[8*i +: 8];
            end
        end
        rd_data_d  = rd_fire ? rd_word : rd_data_q;
        rd_valid_d = rd_fire;
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be_i[i]) begin
                    mem[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CLEAR;
            clr_cnt_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef PARITY_EN
    logic [BE_W-1:0] par_mem [DEPTH];
    logic [BE_W-1:0] wr_par;
    logic [BE_W-1:0] rd_par;
    logic [BE_W-1:0] rd_word_par;
    logic            parity_err_q, parity_err_d;

    // Even parity: the stored bit makes each byte plus its parity bit have an even count of ones.
    always_comb begin
        wr_par      = '0;
        rd_word_par = '0;
        rd_par      = par_mem[rd_addr_i];
        for (int i = 0; i < BE_W; i++) begin
            wr_par[i]      = ^wr_data_i[8*i +: 8];
            rd_word_par[i] = ^rd_word[8*i +: 8];
            if (fwd && wr_be_i[i]) begin
                rd_par[i] = wr_par[i];
            end
        end
        parity_err_d = rd_fire & (|(rd_par ^ rd_word_par));
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            par_mem[clr_cnt_q] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be_i[i]) begin
                    par_mem[wr_addr_i][i] <= wr_par[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign busy_o     = busy;

endmodule

// File: tb/tb_ram_dp_clr.sv
// Randomised and directed checks of ram_dp_clr against a word-array reference model.
module tb_ram_dp_clr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena_i = 1'b0;
    logic        wr_en_i = 1'b0;
    logic [4:0]  wr_addr_i = '0;
    logic [31:0] wr_data_i = '0;
    logic [3:0]  wr_be_i = '0;
    logic        rd_en_i = 1'b0;
    logic [4:0]  rd_addr_i = '0;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        clr_req_i = 1'b0;
    logic        busy_o;
    logic        parity_err_o;

    int checks = 0;
    int errors = 0;

    // Reference model: plain word array, write applied before read gives write-first behaviour.
    logic [31:0] mem_m [32];
    logic [31:0] exp_rd;
    logic        exp_valid;
    logic        m_busy;
    int          m_cnt;

    ram_dp_clr #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena_i        (ena_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_be_i      (wr_be_i),
        .rd_en_i      (rd_en_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .clr_req_i    (clr_req_i),
        .busy_o       (busy_o),
        .parity_err_o (parity_err_o)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy    = 1'b1;
        m_cnt     = 0;
        exp_rd    = '0;
        exp_valid = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic [3:0] be,
                              input logic re, input logic [4:0] ra, input logic c);
        exp_valid = 1'b0;
        if (m_busy) begin
            mem_m[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == 32) m_busy = 1'b0;
        end else begin
            if (e && we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[wa][8*b +: 8] = wd[8*b +: 8];
                end
            end
            if (e && re) begin
                exp_rd    = mem_m[ra];
                exp_valid = 1'b1;
            end
            if (c) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, and update the model.
    task automatic cyc(input logic e, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic re, input logic [4:0] ra, input logic c);
        ena_i     = e;
        wr_en_i   = we;
        wr_addr_i = wa;
        wr_data_i = wd;
        wr_be_i   = be;
        rd_en_i   = re;
        rd_addr_i = ra;
        clr_req_i = c;
        @(posedge clk);
        #1;
        model_step(e, we, wa, wd, be, re, ra, c);
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        #12;
        checks++;
        if (rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data_o); end
        checks++;
        if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid_o); end
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy_o); end
        checks++;
        if (parity_err_o !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", parity_err_o); end
        model_reset();
        rst_n = 1'b1;
        n = 0;
        while (busy_o === 1'b1 && n < 100) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n != 32) begin errors++; $display("FAIL init_clear_len got %0d want 32", n); end
        for (int a = 0; a < 32; a++) begin
            cyc(1, 0, 0, 0, 0, 1, 5'(a), 0);
            checks++;
            if (rd_data_o !== 32'h0 || rd_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL init_zero addr %0d got %h/%b want 0/1", a, rd_data_o, rd_valid_o);
            end
        end
    endtask

    task automatic test_byte_write();
        cyc(1, 1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        checks++;
        if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL write_no_valid got %b want 0", rd_valid_o); end
        cyc(1, 0, 0, 0, 0, 1, 3, 0);
        checks++;
        if (rd_data_o !== 32'hDEADBEEF || rd_valid_o !== 1'b1) begin
            errors++; $display("FAIL full_write got %h/%b want deadbeef/1", rd_data_o, rd_valid_o);
        end
        cyc(0, 0, 0, 0, 0, 1, 3, 0);
        checks++;
        if (rd_data_o !== 32'hDEADBEEF || rd_valid_o !== 1'b0) begin
            errors++; $display("FAIL ena_low_hold got %h/%b want deadbeef/0", rd_data_o, rd_valid_o);
        end
        cyc(1, 1, 3, 32'h11223344, 4'b0101, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 3, 0);
        checks++;
        if (rd_data_o !== 32'hDE22BE44 || rd_valid_o !== 1'b1) begin
            errors++; $display("FAIL partial_write got %h/%b want de22be44/1", rd_data_o, rd_valid_o);
        end
        cyc(1, 1, 3, 32'hFFFFFFFF, 4'b0000, 1, 3, 0);
        checks++;
        if (rd_data_o !== 32'hDE22BE44) begin errors++; $display("FAIL be_zero got %h want de22be44", rd_data_o); end
    endtask

    task automatic test_read_during_write();
        cyc(1, 1, 7, 32'hCAFEF00D, 4'hF, 1, 7, 0);
        checks++;
        if (rd_data_o !== 32'hCAFEF00D || rd_valid_o !== 1'b1) begin
            errors++; $display("FAIL rdw_same got %h/%b want cafef00d/1", rd_data_o, rd_valid_o);
        end
        cyc(1, 1, 8, 32'h12345678, 4'hF, 1, 7, 0);
        checks++;
        if (rd_data_o !== 32'hCAFEF00D) begin errors++; $display("FAIL rdw_diff got %h want cafef00d", rd_data_o); end
        cyc(1, 1, 7, 32'h00000000, 4'b0011, 1, 7, 0);
        checks++;
        if (rd_data_o !== 32'hCAFE0000) begin errors++; $display("FAIL rdw_merge got %h want cafe0000", rd_data_o); end
        cyc(1, 0, 0, 0, 0, 1, 8, 0);
        checks++;
        if (rd_data_o !== 32'h12345678) begin errors++; $display("FAIL rdw_other got %h want 12345678", rd_data_o); end
    endtask

    task automatic test_random();
        logic        e, we, re;
        logic [4:0]  wa, ra;
        logic [31:0] wd;
        logic [3:0]  be;
        for (int k = 0; k < 400; k++) begin
            e  = ($urandom_range(0, 9) != 0);
            we = $urandom_range(0, 1) == 1;
            re = $urandom_range(0, 2) != 0;
            wa = 5'($urandom_range(0, 7));
            ra = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) wa = 5'($urandom);
            wd = $urandom;
            be = 4'($urandom);
            cyc(e, we, wa, wd, be, re, ra, 0);
            checks++;
            if (rd_data_o !== exp_rd || rd_valid_o !== exp_valid || busy_o !== m_busy || parity_err_o !== 1'b0) begin
                errors++;
                $display("FAIL random cyc %0d got %h/%b/%b/%b want %h/%b/%b/0",
                         k, rd_data_o, rd_valid_o, busy_o, parity_err_o, exp_rd, exp_valid, m_busy);
            end
        end
        for (int a = 0; a < 32; a++) begin
            cyc(1, 0, 0, 0, 0, 1, 5'(a), 0);
            checks++;
            if (rd_data_o !== exp_rd) begin errors++; $display("FAIL random_dump addr %0d got %h want %h", a, rd_data_o, exp_rd); end
        end
    endtask

    task automatic test_clear();
        int          n;
        logic [31:0] held;
        cyc(1, 1, 5, 32'h0000_55AA, 4'hF, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 5, 1);
        held = rd_data_o;
        checks++;
        if (busy_o !== 1'b1 || rd_data_o !== 32'h0000_55AA) begin
            errors++; $display("FAIL clr_start got %b/%h want 1/000055aa", busy_o, rd_data_o);
        end
        n = 0;
        while (busy_o === 1'b1 && n < 100) begin
            cyc(1, 1, 5'($urandom), $urandom | 32'h1, 4'hF, 1, 5'($urandom), 1);
            n++;
            checks++;
            if (rd_valid_o !== exp_valid || rd_data_o !== held) begin
                errors++; $display("FAIL clr_ignore got %h/%b want %h/%b", rd_data_o, rd_valid_o, held, exp_valid);
            end
        end
        checks++;
        if (n != 32) begin errors++; $display("FAIL clr_len got %0d want 32", n); end
        for (int a = 0; a < 32; a++) begin
            cyc(1, 0, 0, 0, 0, 1, 5'(a), 0);
            checks++;
            if (rd_data_o !== 32'h0) begin errors++; $display("FAIL clr_zero addr %0d got %h want 0", a, rd_data_o); end
        end
        cyc(1, 1, 9, 32'hA1B2C3D4, 4'hF, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1, 9, 1);
        for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b1 || rd_data_o !== 32'h0 || rd_valid_o !== 1'b0) begin
            errors++; $display("FAIL midclr_reset got %b/%h/%b want 1/0/0", busy_o, rd_data_o, rd_valid_o);
        end
        model_reset();
        #2 rst_n = 1'b1;
        n = 0;
        while (busy_o === 1'b1 && n < 100) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        checks++;
        if (n != 32) begin errors++; $display("FAIL midclr_len got %0d want 32", n); end
        cyc(1, 0, 0, 0, 0, 1, 9, 0);
        checks++;
        if (rd_data_o !== 32'h0) begin errors++; $display("FAIL midclr_zero got %h want 0", rd_data_o); end
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        cyc(1, 1, 2, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
        cyc(1, 1, 3, 32'h0F0F0F01, 4'hF, 0, 0, 0);
        force dut.par_mem[2][0] = 1'b1;
        cyc(1, 0, 0, 0, 0, 1, 2, 0);
        checks++;
        if (parity_err_o !== 1'b1 || rd_valid_o !== 1'b1) begin
            errors++; $display("FAIL parity_bad got %b/%b want 1/1", parity_err_o, rd_valid_o);
        end
        release dut.par_mem[2][0];
        cyc(1, 0, 0, 0, 0, 1, 3, 0);
        checks++;
        if (parity_err_o !== 1'b0 || rd_data_o !== 32'h0F0F0F01) begin
            errors++; $display("FAIL parity_clean got %b/%h want 0/0f0f0f01", parity_err_o, rd_data_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_byte_write();
        test_read_during_write();
        test_random();
        test_clear();
`ifdef PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
